// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
package imem_pkg;

  localparam int IMEM_ADDR_W = 32;
  localparam int IMEM_DATA_W = 32;
  localparam logic [IMEM_DATA_W-1:0] IMEM_NOP = 32'h0;

  // Index of a requesting port; also the encoding of the priority pointer.
  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } imem_port_e;

endpackage

// File: rtl/imem_rr_pick.sv
// Two-way combinational picker: a lone requester always wins, and on
// contention the port named by i_prio wins.
module imem_rr_pick
  import imem_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  imem_port_e i_prio,
  output logic       o_gnt0,
  output logic       o_gnt1
);

  // Select at most one winner from the two requests.
  always_comb begin
    // NOTE: every output gets a default first so no path can leave it unassigned and infer a latch.
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_req0 && i_req1) begin
      if (i_prio == PORT1) o_gnt1 = 1'b1;
      else                 o_gnt0 = 1'b1;
    end else begin
      o_gnt0 = i_req0;
      o_gnt1 = i_req1;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Two-port arbiter in front of a combinational instruction ROM.
// One grant per cycle, registered responses one cycle later, address
// checking with error responses and a saturating error counter.
// Define IMEM_ARB_ROUND_ROBIN_EN for alternating priority on contention;
// otherwise port 0 always wins and no priority register exists.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter logic [23:0] BASE_ADDRESS = 24'd0,
  parameter int          ERR_CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [IMEM_ADDR_W-1:0] addr0,
  input  logic [IMEM_ADDR_W-1:0] addr1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   rvalid0,
  output logic                   rvalid1,
  output logic [IMEM_DATA_W-1:0] rdata0,
  output logic [IMEM_DATA_W-1:0] rdata1,
  output logic                   rerr0,
  output logic                   rerr1,
  output logic [IMEM_ADDR_W-1:0] rom_addr,
  input  logic [IMEM_DATA_W-1:0] rom_data,
  output logic [ERR_CNT_W-1:0]   err_count
);

  imem_port_e             w_prio;
  logic                   w_pick_gnt0;
  logic                   w_pick_gnt1;
  logic                   w_grant;
  logic [IMEM_ADDR_W-1:0] w_sel_addr;
  logic                   w_err;

  logic                   r_rvalid0;
  logic                   r_rvalid1;
  logic [IMEM_DATA_W-1:0] r_rdata0;
  logic [IMEM_DATA_W-1:0] r_rdata1;
  logic                   r_rerr0;
  logic                   r_rerr1;
  logic [IMEM_ADDR_W-1:0] r_last_addr;
  logic [ERR_CNT_W-1:0]   r_err_count;

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  imem_port_e r_prio;

  // Hand priority to the port that lost the most recent grant.
  always_ff @(posedge clk) begin
    if (reset)        r_prio <= PORT0;
    else if (w_grant) r_prio <= gnt0 ? PORT1 : PORT0;
  end

  assign w_prio = r_prio;
`else
  assign w_prio = PORT0;
`endif

  imem_rr_pick u_pick (
    .i_req0 (req0),
    .i_req1 (req1),
    .i_prio (w_prio),
    .o_gnt0 (w_pick_gnt0),
    .o_gnt1 (w_pick_gnt1)
  );

  // Grants are suppressed while reset is high so nothing is accepted then.
  assign gnt0    = w_pick_gnt0 & ~reset;
  assign gnt1    = w_pick_gnt1 & ~reset;
  assign w_grant = gnt0 | gnt1;

  assign w_sel_addr = gnt1 ? addr1 : addr0;
  assign w_err      = (w_sel_addr[1:0] != 2'b00) || (w_sel_addr[31:8] != BASE_ADDRESS);

  // The ROM sees the granted address, or the last one when idle.
  assign rom_addr = reset ? '0 : (w_grant ? w_sel_addr : r_last_addr);

  // Register the response for the granted port and count error responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= IMEM_NOP;
      r_rdata1    <= IMEM_NOP;
      r_rerr0     <= 1'b0;
      r_rerr1     <= 1'b0;
      r_last_addr <= '0;
      r_err_count <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      r_rvalid0 <= gnt0;
      r_rvalid1 <= gnt1;
      r_rerr0   <= gnt0 & w_err;
      r_rerr1   <= gnt1 & w_err;
      r_rdata0  <= (gnt0 && !w_err) ? rom_data : IMEM_NOP;
      r_rdata1  <= (gnt1 && !w_err) ? rom_data : IMEM_NOP;
      if (w_grant) r_last_addr <= w_sel_addr;
      if (w_grant && w_err && (r_err_count != '1)) r_err_count <= r_err_count + 1'b1;
    end
  end

  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign rerr0     = r_rerr0;
  assign rerr1     = r_rerr1;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed sequences with literal
// expectations plus randomized traffic checked every cycle against a
// transaction-level model. Expectations follow IMEM_ARB_ROUND_ROBIN_EN.
`timescale 1ns/1ps
module tb_imem_arbiter;

  localparam logic [23:0] BASE    = 24'd0;
  localparam int          CW      = 8;
  localparam int          CNT_MAX = (1 << CW) - 1;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [31:0]   addr0, addr1;
  logic          gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
  logic [31:0]   rdata0, rdata1, rom_addr, rom_data;
  logic [CW-1:0] err_count;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  imem_arbiter #(.BASE_ADDRESS(BASE), .ERR_CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .req1      (req1),
    .addr0     (addr0),
    .addr1     (addr1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .rerr0     (rerr0),
    .rerr1     (rerr1),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .err_count (err_count)
  );

  // ROM contents: each word is distinct and easy to recognise.
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return 32'hDEAD_0000 | {16'h0, a[15:0]};
  endfunction

  assign rom_data = rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          model_ready = 1'b0;
  bit          m_prio;
  logic [31:0] m_last;
  bit          m_rv[2];
  bit          m_re[2];
  logic [31:0] m_rd[2];
  int          m_cnt;

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || ((a >> 8) != 32'(BASE));
  endfunction

  // Winning port index, or -1 when nobody requests.
  function automatic int pick(input bit r0, input bit r1, input bit p);
    if (r0 && r1) return RR_EN ? int'(p) : 0;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_update();
    int          w;
    logic [31:0] a;
    bit          e;
    if (reset) begin
      m_prio = 1'b0; m_last = '0; m_cnt = 0;
      for (int p = 0; p < 2; p++) begin m_rv[p] = 0; m_re[p] = 0; m_rd[p] = '0; end
      model_ready = 1'b1;
    end else begin
      w = pick(req0, req1, m_prio);
      for (int p = 0; p < 2; p++) begin m_rv[p] = 0; m_re[p] = 0; m_rd[p] = '0; end
      if (w >= 0) begin
        a = (w == 1) ? addr1 : addr0;
        e = addr_bad(a);
        m_rv[w] = 1'b1;
        m_re[w] = e;
        m_rd[w] = e ? 32'h0 : rom_fn(a);
        if (e && m_cnt < CNT_MAX) m_cnt++;
        m_last = a;
        m_prio = (w == 0);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_update();
  end

  // Per-cycle compare of every output against the model.
  int          c_w;
  logic [31:0] c_sel;
  initial forever begin
    @(negedge clk);
    if (model_ready) begin
      c_w   = reset ? -1 : pick(req0, req1, m_prio);
      c_sel = (c_w == 1) ? addr1 : addr0;
      check("m_gnt0", gnt0, c_w == 0);
      check("m_gnt1", gnt1, c_w == 1);
      check("m_gnt_excl", gnt0 & gnt1, 0);
      check("m_rom_addr", rom_addr, reset ? 32'h0 : ((c_w >= 0) ? c_sel : m_last));
      check("m_rvalid0", rvalid0, m_rv[0]);
      check("m_rvalid1", rvalid1, m_rv[1]);
      check("m_rerr0", rerr0, m_re[0]);
      check("m_rerr1", rerr1, m_re[1]);
      check("m_rdata0", rdata0, m_rd[0]);
      check("m_rdata1", rdata1, m_rd[1]);
      check("m_err_count", err_count, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic drive(input bit r0, input logic [31:0] a0, input bit r1, input logic [31:0] a1);
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [5:0] w;
    logic [1:0] lo;
    w  = 6'($urandom_range(0, 63));
    lo = 2'($urandom_range(1, 3));
    case ($urandom_range(0, 3))
      0, 1:    return {BASE, w, 2'b00};
      2:       return {BASE, w, lo};
      default: return $urandom;
    endcase
  endfunction

  bit last_g0, last_g1;
  int pw;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0);
    repeat (3) step();
    reset = 1'b0;

    // Reset state.
    sample();
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_err_count", err_count, 0);
    check("rst_rom_addr", rom_addr, 0);
    step();

    // Sustained contention for four cycles.
    drive(1, 32'h00, 1, 32'h04);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) drive(0, 0, 0, 0);
      sample();
      if (k < 4) begin
        check("both_gnt0", gnt0, RR_EN ? (k % 2 == 0) : 1'b1);
        check("both_gnt1", gnt1, RR_EN ? (k % 2 == 1) : 1'b0);
      end
      if (k > 0) begin
        pw = RR_EN ? (k - 1) % 2 : 0;
        check("both_rvalid0", rvalid0, pw == 0);
        check("both_rvalid1", rvalid1, pw == 1);
        check("both_rdata", (pw == 1) ? rdata1 : rdata0, (pw == 1) ? 32'hDEAD0004 : 32'hDEAD0000);
      end
      step();
    end

    // Single request from port 0 at word 3.
    drive(1, 32'h0C, 0, 0);
    sample();
    check("single_gnt0", gnt0, 1);
    check("single_gnt1", gnt1, 0);
    check("single_rom_addr", rom_addr, 32'h0C);
    step();
    drive(0, 0, 0, 0);
    sample();
    check("single_rvalid0", rvalid0, 1);
    check("single_rdata0", rdata0, 32'hDEAD000C);
    check("single_rerr0", rerr0, 0);
    check("single_rvalid1", rvalid1, 0);
    check("idle_rom_addr_hold", rom_addr, 32'h0C);
    step();

    // Misaligned, then out-of-range, on port 1.
    drive(0, 0, 1, 32'h06);
    sample();
    check("err_gnt1", gnt1, 1);
    step();
    drive(0, 0, 1, 32'h0000_0104);
    sample();
    check("err1_rvalid1", rvalid1, 1);
    check("err1_rerr1", rerr1, 1);
    check("err1_rdata1", rdata1, 0);
    check("err1_count", err_count, 1);
    step();
    drive(0, 0, 0, 0);
    sample();
    check("err2_rvalid1", rvalid1, 1);
    check("err2_rerr1", rerr1, 1);
    check("err2_rdata1", rdata1, 0);
    check("err2_count", err_count, 2);
    step();

    // Randomized traffic; a pending request is held until granted.
    last_g0 = 1'b1;
    last_g1 = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (!req0 || last_g0) begin req0 = 1'($urandom_range(0, 1)); addr0 = rand_addr(); end
      if (!req1 || last_g1) begin req1 = 1'($urandom_range(0, 1)); addr1 = rand_addr(); end
      sample();
      last_g0 = gnt0;
      last_g1 = gnt1;
      step();
    end
    drive(0, 0, 0, 0);
    step();

    // Back-to-back misaligned requests drive the counter into saturation.
    for (int i = 0; i < 300; i++) begin
      drive(1, {BASE, 6'(i), 2'b01}, 0, 0);
      step();
    end
    drive(0, 0, 0, 0);
    sample();
    check("sat_err_count", err_count, 8'd255);
    step();

    // Reset arriving while both ports request.
    drive(1, 32'h10, 0, 0);
    sample();
    check("pre_rst_gnt0", gnt0, 1);
    step();
    drive(1, 32'h20, 1, 32'h24);
    reset = 1'b1;
    sample();
    check("in_rst_gnt0", gnt0, 0);
    check("in_rst_gnt1", gnt1, 0);
    check("in_rst_rom_addr", rom_addr, 0);
    step();
    reset = 1'b0;
    sample();
    check("post_rst_rvalid0", rvalid0, 0);
    check("post_rst_rvalid1", rvalid1, 0);
    check("post_rst_rerr0", rerr0, 0);
    check("post_rst_rdata0", rdata0, 0);
    check("post_rst_rdata1", rdata1, 0);
    check("post_rst_err_count", err_count, 0);
    check("post_rst_gnt0", gnt0, 1);
    check("post_rst_gnt1", gnt1, 0);
    step();
    drive(0, 0, 0, 0);
    sample();
    check("post_rst_rdata0_resp", rdata0, 32'hDEAD0020);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 The block SHALL have parameter BASE_ADDRESS, default 24'd0, which gives the value of address[31:8] that selects the instruction ROM.
REQ-002 The block SHALL have parameter ERR_CNT_W, default 8, which gives the width of the error counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have ports req0 / req1, input, 1 bit each: fetch request from port 0 (scalar pipeline) and port 1 (vector unit).
REQ-006 The block SHALL have ports addr0 / addr1, input, 32 bits each: byte address of the request.
REQ-007 The block SHALL have ports gnt0 / gnt1, output, 1 bit each: the request is accepted this cycle (combinational).
REQ-008 The block SHALL have ports rvalid0 / rvalid1, output, 1 bit each: response valid (registered).
REQ-009 The block SHALL have ports rdata0 / rdata1, output, 32 bits each: instruction word (registered).
REQ-010 The block SHALL have ports rerr0 / rerr1, output, 1 bit each: the response is an error (registered).
REQ-011 The block SHALL have port rom_addr, output, 32 bits: address driven to the combinational ROM.
REQ-012 The block SHALL have port rom_data, input, 32 bits: ROM read data, valid in the same cycle.
REQ-013 The block SHALL have port err_count, output, ERR_CNT_W bits: saturating count of error responses.

Function
REQ-014 The block SHALL grant at most one requester per cycle: gnt0 & gnt1 == 0 always.
REQ-015 When only one req is high, the block SHALL grant that port in the same cycle.
REQ-016 The block SHALL use a 1-bit priority pointer prio; when both reqs are high, the port equal to prio wins.
REQ-017 After each grant, the block SHALL set prio to the port that lost; with no grant, prio SHALL hold.
REQ-018 The block SHALL drive rom_addr with the granted port's address; with no grant it SHALL hold the last granted address.
REQ-019 Latency SHALL be 1 cycle: a grant in cycle N gives rvalid on the granted port in cycle N+1 for exactly one cycle, carrying rom_data captured in cycle N.
REQ-020 The block SHALL accept back-to-back grants with one new grant per cycle and no bubble.
REQ-021 A requester SHALL hold req and addr stable until it sees gnt; a req dropped before gnt is discarded with no response.
REQ-022 An address with addr[1:0] != 0 SHALL be an error: response with rerr=1 and rdata=32'h0; the ROM value is ignored.
REQ-023 An address with addr[31:8] != BASE_ADDRESS SHALL be an error with the same response as REQ-022.
REQ-024 Each error response SHALL increment err_count by 1, saturating at all-ones.
REQ-025 rvalid/rerr/rdata of the port not responding SHALL be 0 in that cycle.

Reset
REQ-026 While reset is high, the block SHALL hold gnt0 = gnt1 = 0, rvalid = 0, rerr = 0, rdata = 0, rom_addr = 0, err_count = 0 and prio = 0.
REQ-027 A grant in the cycle reset asserts SHALL produce no response; the first grant after reset release SHALL go to port 0 if both request.

Configuration
REQ-028 The macro IMEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration mode.
REQ-029 With IMEM_ARB_ROUND_ROBIN_EN defined, the block SHALL arbitrate as in REQ-016/017.
REQ-030 Without IMEM_ARB_ROUND_ROBIN_EN, port 0 SHALL always win, and the prio register SHALL be absent.

Structure
REQ-031 A shared package imem_pkg SHALL hold the constants IMEM_ADDR_W=32, IMEM_DATA_W=32 and IMEM_NOP=32'h0, and the port-index typedef.
REQ-032 The block SHALL instantiate one sub-module, imem_rr_pick: a 2-way combinational picker from req0, req1 and prio to gnt0, gnt1.

Verification
REQ-033 The bench SHALL drive req0=1, addr0=0x0C only, and check gnt0 in the same cycle, then rvalid0=1 with rdata0=ROM[3] in the next cycle.
REQ-034 The bench SHALL hold both reqs for 4 cycles (addr0=0x00, addr1=0x04) with round-robin on, and check grants 0,1,0,1 and responses alternating with a 1-cycle lag.
REQ-035 The bench SHALL repeat REQ-034 with the macro off, and check gnt0 in all 4 cycles and gnt1 never.
REQ-036 The bench SHALL request addr1=0x06, then addr1=0x00000104, and check rerr1=1, rdata1=0 for both and err_count=2.
REQ-037 The bench SHALL drive 300 misaligned requests with ERR_CNT_W=8, and check err_count saturates at 255.
REQ-038 The bench SHALL assert reset in the cycle a grant occurs, and check no rvalid in the next cycle, all outputs 0, and the first post-reset contention won by port 0.
